ip_top_align_rmw: RTL and testbench
===================================

Name: ip_top_align_rmw

Overview:
- Synthesisable logical-to-physical aligned memory controller. Packs NUMWRDS logical words of WIDTH (+parity) into each physical SRAM row.
- The physical SRAM has no bit-write enable, so logical writes are done as a read-modify-write (RMW) of the full row. This requires a stall handshake.
- Generates parity on write, checks it on read, and reports the physical address of each read.
- Sits between the client port and a single-port SRAM macro with fixed read latency.

Parameters:
- WIDTH, 32, logical word width.
- PARITY, 1, 1 = one even-parity bit per word; 0 = none.
- NUMADDR, 1024, logical depth.
- BITADDR, 10, logical address width.
- NUMWRDS, 4, logical words per physical row.
- BITWRDS, 2, word-select width.
- NUMSROW, 256, physical rows; must be at least ceil(NUMADDR/NUMWRDS).
- BITSROW, 8, row address width.
- SRAM_DELAY, 2, mem_read to mem_dout latency in cycles; must be 1 or more.
- MEMWDTH, WIDTH+PARITY, stored word width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- read  in  1  read request, qualified by ready
- write  in  1  write request, qualified by ready
- addr  in  BITADDR  logical address
- din  in  WIDTH  write data
- ready  out  1  controller can accept a request this cycle
- dout_vld  out  1  read data valid
- dout  out  WIDTH  read data
- serr  out  1  parity error on the returned word; qualified by dout_vld
- padr  out  BITWRDS+BITSROW  {word,row} of the returned word; qualified by dout_vld
- mem_read  out  1  SRAM read strobe
- mem_write  out  1  SRAM write strobe
- mem_addr  out  BITSROW  SRAM row
- mem_din  out  NUMWRDS*MEMWDTH  SRAM write row
- mem_dout  in  NUMWRDS*MEMWDTH  SRAM read row, valid SRAM_DELAY cycles after mem_read

Behaviour:
- Address mapping: row = addr / NUMWRDS; word = addr % NUMWRDS.
- Row layout: word w occupies bits [w*MEMWDTH +: MEMWDTH] as {parity, data}. Parity = ^data, so the XOR of a good word is 0.
- Reset values:
  - State is IDLE.
  - ready=1.
  - dout_vld=0; serr=0; dout=0; padr=0.
  - mem_read=0; mem_write=0.
  - All in-flight read pipeline entries are cleared.
- Request acceptance:
  - A request is accepted only when ready=1 and addr < NUMADDR.
  - An out-of-range request is dropped: no SRAM access, no dout_vld, ready unaffected.
  - If read and write are both asserted, write wins and the read is dropped.
- Read path:
  - mem_read and mem_addr are driven combinationally in the acceptance cycle t.
  - A pipeline of length SRAM_DELAY carries {valid, word, row}.
  - At t+SRAM_DELAY: dout_vld=1; dout is the selected word's data extracted from mem_dout; serr = PARITY & ^(selected word incl. parity); padr = {word,row}.
  - Reads may be accepted back-to-back; one result per cycle, in order.
- State machine:
  - IDLE: ready=1. An accepted write issues mem_read on the target row, latches word/din/row, loads the counter with SRAM_DELAY-1, and goes to RMW_WAIT (or to RMW_WR if SRAM_DELAY==1).
  - RMW_WAIT: ready=0. The counter decrements; at 0 the next state is RMW_WR.
  - RMW_WR: mem_dout holds the row. Merge: the target word is replaced with {^din, din}; all other words are copied bit-exact, including bad parity, so existing errors stay detectable. Drive mem_write with mem_addr=row and mem_din=merged. ready=0. Next state is IDLE.
  - A write therefore occupies SRAM_DELAY+1 cycles; ready returns in the cycle after mem_write.
- Concurrency:
  - Reads accepted before a write still complete normally while the RMW is in progress.
  - mem_read and mem_write are never asserted in the same cycle.
- SRAM contract: a read issued in the cycle after a write to the same row returns the new data. No bypass logic is required.
- PARITY=0: parity bits are absent and serr is 0.
- Reset mid-operation (including during RMW_WAIT or RMW_WR): state returns to IDLE, no mem_write is issued in the reset cycle, and pipeline valids are cleared. The contents of the row being modified keep their old value.

Test Plan (WIDTH=8, PARITY=1, NUMADDR=12, NUMWRDS=4, BITWRDS=2, NUMSROW=3, BITSROW=2, SRAM_DELAY=2, zero-initialised SRAM model):
- Reset held 3 cycles -> ready=1, dout_vld=0, mem_read=0, mem_write=0.
- Write addr 5 din 0xA5 at cycle t -> mem_read row 1 at t; ready=0 at t+1 and t+2; mem_write row 1 at t+2 with word1 = 9'h0A5 and words 0,2,3 = 0; ready=1 at t+3.
- Read addr 5 at t+3 -> dout_vld at t+5 with dout=0xA5, serr=0, padr=4'b01_01.
- Flip bit 0 of word1 in the SRAM model, then read addr 5 -> serr=1. Then write addr 4 din 0x01 -> mem_din word1 is the flipped value (preserved) and word0 = 9'h101. Then read addr 4 -> serr=0, dout=0x01.
- Reads of addrs 0,1,2,3 on consecutive cycles -> dout_vld high for 4 consecutive cycles, outputs in order, padr word fields 0,1,2,3.
- Edge cases:
  - Assert rst in RMW_WAIT -> no mem_write; ready=1 after reset.
  - read and write both asserted on addr 2 -> only the write RMW occurs.
  - addr 12 -> no SRAM access and no dout_vld.

Source files
------------

// File: rtl/ip_top_align_rmw.sv
// Logical-to-physical aligned memory controller: packs NUMWRDS parity-protected
// words per SRAM row and performs logical writes as a row read-modify-write.
module ip_top_align_rmw #(
  parameter int WIDTH      = 32,
  parameter int PARITY     = 1,
  parameter int NUMADDR    = 1024,
  parameter int BITADDR    = 10,
  parameter int NUMWRDS    = 4,
  parameter int BITWRDS    = 2,
  parameter int NUMSROW    = 256,
  parameter int BITSROW    = 8,
  parameter int SRAM_DELAY = 2,
  parameter int MEMWDTH    = WIDTH + PARITY
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         read,
  input  logic                         write,
  input  logic [BITADDR-1:0]           addr,
  input  logic [WIDTH-1:0]             din,
  output logic                         ready,
  output logic                         dout_vld,
  output logic [WIDTH-1:0]             dout,
  output logic                         serr,
  output logic [BITWRDS+BITSROW-1:0]   padr,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [BITSROW-1:0]           mem_addr,
  output logic [NUMWRDS*MEMWDTH-1:0]   mem_din,
  input  logic [NUMWRDS*MEMWDTH-1:0]   mem_dout
);

  localparam int ROWW  = NUMWRDS * MEMWDTH;
  localparam int CNTW  = (SRAM_DELAY > 1) ? $clog2(SRAM_DELAY) : 1;
  // The accepted range never reaches past the rows that physically exist.
  localparam int LIMIT = (NUMADDR < NUMSROW * NUMWRDS) ? NUMADDR : NUMSROW * NUMWRDS;

  typedef enum logic [1:0] {IDLE, RMW_WAIT, RMW_WR} state_t;

  typedef struct packed {
    logic               vld;
    logic [BITWRDS-1:0] word;
    logic [BITSROW-1:0] row;
  } rd_tag_t;

  function automatic logic [MEMWDTH-1:0] encode(input logic [WIDTH-1:0] data);
    logic [MEMWDTH-1:0] w;
    w = MEMWDTH'(data);
    if (PARITY != 0) w[MEMWDTH-1] = ^data;
    return w;
  endfunction

  state_t             state, state_nxt;
  logic [CNTW-1:0]    cnt, cnt_nxt;
  logic [BITWRDS-1:0] word_q;
  logic [BITSROW-1:0] row_q;
  logic [WIDTH-1:0]   din_q;
  logic               in_range, rd_acc, wr_acc;
  logic [BITWRDS-1:0] req_word;
  logic [BITSROW-1:0] req_row;
  rd_tag_t            pipe [SRAM_DELAY];
  rd_tag_t            tail;
  logic [MEMWDTH-1:0] sel;
  logic [ROWW-1:0]    merged;

  assign req_row  = BITSROW'(32'(addr) / NUMWRDS);
  assign req_word = BITWRDS'(32'(addr) % NUMWRDS);
  assign in_range = 32'(addr) < LIMIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    rd_acc    = 1'b0;
    wr_acc    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = req_row;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (!rst && in_range) begin
          wr_acc = write;
          rd_acc = read & ~write;
        end
        mem_read = wr_acc | rd_acc;
        if (wr_acc) begin
          cnt_nxt = CNTW'(SRAM_DELAY - 1);
          if (SRAM_DELAY == 1) state_nxt = RMW_WR;
          else                 state_nxt = RMW_WAIT;
        end
      end
      RMW_WAIT: begin
        cnt_nxt = cnt - CNTW'(1);
        if (cnt_nxt == '0) state_nxt = RMW_WR;
      end
      RMW_WR: begin
        // A reset landing on this cycle must not commit a half-finished row.
        mem_write = ~rst;
        mem_addr  = row_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: pure datapath registers carry no reset; they are only consumed after
  // a write has been accepted, which reloads them.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      word_q <= req_word;
      row_q  <= req_row;
      din_q  <= din;
    end
  end

  always_ff @(posedge clk) begin
    pipe[0] <= '{vld: rd_acc, word: req_word, row: req_row};
    for (int i = 1; i < SRAM_DELAY; i++) pipe[i] <= pipe[i-1];
    if (rst) begin
      for (int i = 0; i < SRAM_DELAY; i++) pipe[i].vld <= 1'b0;
    end
  end

  always_comb begin
    tail     = pipe[SRAM_DELAY-1];
    sel      = mem_dout[int'(tail.word)*MEMWDTH +: MEMWDTH];
    dout_vld = tail.vld & ~rst;
    dout     = dout_vld ? sel[WIDTH-1:0] : '0;
    serr     = dout_vld & (PARITY != 0) & (^sel);
    padr     = dout_vld ? {tail.word, tail.row} : '0;
  end

  // Untouched words are copied bit-exact so stored parity errors survive.
  always_comb begin
    merged = mem_dout;
    merged[int'(word_q)*MEMWDTH +: MEMWDTH] = encode(din_q);
  end

  assign mem_din = merged;

endmodule

// File: tb/tb_ip_top_align_rmw.sv
// Self-checking bench for ip_top_align_rmw: an SRAM model, a word-level memory
// model that predicts every cycle's outputs, and directed literal checks.
module tb_ip_top_align_rmw;

  localparam int N = 256;

  logic        clk, rst, read, write;
  logic [3:0]  addr;
  logic [7:0]  din, dout;
  logic        ready, dout_vld, serr, mem_read, mem_write;
  logic [3:0]  padr;
  logic [1:0]  mem_addr;
  logic [35:0] mem_din;
  logic [35:0] mem_dout = '0;

  ip_top_align_rmw #(
    .WIDTH(8), .PARITY(1), .NUMADDR(12), .BITADDR(4), .NUMWRDS(4), .BITWRDS(2),
    .NUMSROW(3), .BITSROW(2), .SRAM_DELAY(2)
  ) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .din(din),
    .ready(ready), .dout_vld(dout_vld), .dout(dout), .serr(serr), .padr(padr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: two-cycle read latency, write visible to the next read.
  logic [35:0] sram [4] = '{default: '0};
  logic [35:0] rd_d1 = '0;
  bit          flip_en = 1'b0;
  int          flip_row = 0, flip_bit = 0;
  always @(posedge clk) begin
    if (mem_write) sram[mem_addr] <= mem_din;
    if (flip_en) sram[flip_row][flip_bit] <= ~sram[flip_row][flip_bit];
    rd_d1    <= mem_read ? sram[mem_addr] : '0;
    mem_dout <= rd_d1;
  end

  int n_chk = 0, n_pass = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Word-level model of the logical memory ({parity,data} per word).
  logic [8:0] mw [3][4];
  bit          e_ready [N], e_mrd [N], e_mwr [N], e_vld [N], e_serr [N];
  logic [1:0]  e_maddr [N];
  logic [35:0] e_mdin  [N];
  logic [7:0]  e_dout  [N];
  logic [3:0]  e_padr  [N];

  function automatic logic [8:0] enc(input logic [7:0] d);
    return {^d, d};
  endfunction

  function automatic logic [35:0] row_img(input int r);
    logic [35:0] v;
    for (int w = 0; w < 4; w++) v[w*9 +: 9] = mw[r][w];
    return v;
  endfunction

  // Compare process and observation counters.
  bit          run = 1'b0;
  int          n_mrd = 0, n_mwr = 0, n_vld = 0;
  logic [35:0] last_mdin = '0;
  logic [1:0]  last_maddr = '0;
  logic [7:0]  last_dout = '0;
  logic        last_serr = 1'b0;
  logic [3:0]  last_padr = '0;

  always @(negedge clk) begin
    if (run && cyc < N) begin
      if (rst) begin
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_read", mem_read, 1'b0);
      end else begin
        check("ready", ready, e_ready[cyc]);
        check("mem_read", mem_read, e_mrd[cyc]);
        check("mem_write", mem_write, e_mwr[cyc]);
        check("dout_vld", dout_vld, e_vld[cyc]);
        if (e_mrd[cyc] || e_mwr[cyc]) check("mem_addr", mem_addr, e_maddr[cyc]);
        if (e_mwr[cyc]) check("mem_din", mem_din, e_mdin[cyc]);
        if (e_vld[cyc]) begin
          check("dout", dout, e_dout[cyc]);
          check("serr", serr, e_serr[cyc]);
          check("padr", padr, e_padr[cyc]);
        end
        if (mem_read) n_mrd++;
        if (mem_write) begin
          n_mwr++;
          last_mdin  = mem_din;
          last_maddr = mem_addr;
        end
        if (dout_vld) begin
          n_vld++;
          last_dout = dout;
          last_serr = serr;
          last_padr = padr;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_read(input int a);
    int c, r, w;
    read = 1'b1; write = 1'b0; addr = 4'(a);
    if (a < 12) begin
      c = cyc; r = a / 4; w = a % 4;
      e_mrd[c] = 1'b1; e_maddr[c] = 2'(r);
      e_vld[c+2]  = 1'b1;
      e_dout[c+2] = mw[r][w][7:0];
      e_serr[c+2] = ^mw[r][w];
      e_padr[c+2] = {2'(w), 2'(r)};
    end
    tick();
    read = 1'b0;
  endtask

  // abort_at: 0 = complete, 1 = reset in the wait cycle, 2 = reset in the write cycle.
  task automatic do_write(input int a, input logic [7:0] d, input bit also_read, input int abort_at);
    int c, r, w;
    logic [35:0] img;
    write = 1'b1; read = also_read; addr = 4'(a); din = d;
    c = cyc; r = a / 4; w = a % 4;
    if (a < 12) begin
      e_mrd[c] = 1'b1; e_maddr[c] = 2'(r);
      e_ready[c+1] = 1'b0;
      if (abort_at == 0) begin
        img = row_img(r);
        img[w*9 +: 9] = enc(d);
        e_ready[c+2] = 1'b0; e_mwr[c+2] = 1'b1; e_maddr[c+2] = 2'(r); e_mdin[c+2] = img;
        mw[r][w] = enc(d);
      end
    end
    tick();
    write = 1'b0; read = 1'b0;
    if (a < 12) begin
      if (abort_at == 1) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end else if (abort_at == 2) begin
        tick(); rst = 1'b1; tick(); rst = 1'b0;
      end else begin
        idle(2);
      end
    end
  endtask

  int m0, w0, v0;

  initial begin
    for (int i = 0; i < N; i++) begin
      e_ready[i] = 1'b1; e_mrd[i] = 1'b0; e_mwr[i] = 1'b0; e_vld[i] = 1'b0; e_serr[i] = 1'b0;
      e_maddr[i] = '0; e_mdin[i] = '0; e_dout[i] = '0; e_padr[i] = '0;
    end
    for (int r = 0; r < 3; r++)
      for (int w = 0; w < 4; w++) mw[r][w] = '0;
    rst = 1'b1; read = 1'b0; write = 1'b0; addr = '0; din = '0;
    idle(3);
    rst = 1'b0; run = 1'b1;
    @(negedge clk);
    check("reset_ready", ready, 1'b1);
    check("reset_dout_vld", dout_vld, 1'b0);
    check("reset_mem_read", mem_read, 1'b0);
    check("reset_mem_write", mem_write, 1'b0);
    check("reset_dout_padr_serr", {dout, padr, serr}, 13'h0);
    tick();

    // Basic write then read back.
    do_write(5, 8'hA5, 1'b0, 0);
    check("wr5_mem_din", last_mdin, 36'h000014A00);
    check("wr5_mem_addr", last_maddr, 2'd1);
    do_read(5); idle(2);
    check("rd5_dout", last_dout, 8'hA5);
    check("rd5_serr", last_serr, 1'b0);
    check("rd5_padr", last_padr, 4'b0101);

    // Corrupt stored parity, detect it, then confirm an RMW preserves it.
    flip_en = 1'b1; flip_row = 1; flip_bit = 9;
    mw[1][1][0] = ~mw[1][1][0];
    tick();
    flip_en = 1'b0;
    do_read(5); idle(2);
    check("rd5_bad_serr", last_serr, 1'b1);
    check("rd5_bad_dout", last_dout, 8'hA4);
    do_write(4, 8'h01, 1'b0, 0);
    check("wr4_mem_din", last_mdin, 36'h000014901);
    do_read(4); idle(2);
    check("rd4_dout", last_dout, 8'h01);
    check("rd4_serr", last_serr, 1'b0);
    check("rd4_padr", last_padr, 4'b0001);

    // Read and write together: only the write happens.
    w0 = n_mwr; v0 = n_vld;
    do_write(2, 8'h3C, 1'b1, 0); idle(1);
    check("both_one_write", n_mwr, w0 + 1);
    check("both_no_read", n_vld, v0);
    check("both_mem_din", last_mdin, 36'h000F00000);

    // Back-to-back reads.
    v0 = n_vld;
    for (int i = 0; i < 4; i++) do_read(i);
    idle(2);
    check("burst_count", n_vld, v0 + 4);
    check("burst_last_padr", last_padr, 4'b1100);

    // Out-of-range requests are dropped.
    m0 = n_mrd; w0 = n_mwr; v0 = n_vld;
    do_read(12);
    do_write(12, 8'hEE, 1'b0, 0);
    idle(3);
    check("oor_no_mem_read", n_mrd, m0);
    check("oor_no_mem_write", n_mwr, w0);
    check("oor_no_dout", n_vld, v0);

    // Reset in the wait cycle, then in the write cycle.
    w0 = n_mwr;
    do_write(6, 8'hFF, 1'b0, 1);
    @(negedge clk);
    check("abort_wait_ready", ready, 1'b1);
    tick();
    check("abort_wait_no_write", n_mwr, w0);
    do_read(6); idle(2);
    check("abort_wait_padr", last_padr, 4'b1001);
    do_write(7, 8'h77, 1'b0, 2);
    idle(1);
    check("abort_wr_no_write", n_mwr, w0);
    v0 = n_vld;
    do_read(7); idle(2);
    check("abort_wr_dout", last_dout, 8'h00);
    check("abort_wr_vld", n_vld, v0 + 1);
    do_read(5); idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
